// File: rtl/infer_ctrl_pkg.sv
// Shared types and constants for the inference sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the sequencer state encoding, the label reported on a watchdog
// expiry, and the MNIST image geometry used as parameter defaults.

package infer_ctrl_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        DRAIN = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [3:0] LABEL_TIMEOUT = 4'hF;

    // 28x28 single-channel grayscale image.
    localparam int MNIST_DIM = 28;
    localparam int MNIST_PIX = MNIST_DIM * MNIST_DIM;

endpackage

// File: rtl/infer_ctrl.sv
// Image loader and run sequencer in front of the conv core.
// Latency: final pixel at t -> fbank write at t+1, core_init at t+2; core_done at d -> m_valid at d+1.
// Backpressure: s_ready is high only in LOAD; the result is held on m_valid/m_label until m_ready.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   s_valid/s_ready/s_data/s_last     8-bit pixel stream in
//   fbank_waddr/fdata_w/fbank_wen     fmap bank write port (owned while load_sel=1)
//   load_sel                          steers the top-level fbank write mux to this block
//   core_init/core_done/core_label    core start pulse, completion pulse and result
//   m_valid/m_ready/m_label           classification result out (4'hF on watchdog expiry)
//   len_err                           one-cycle pulse on an image of the wrong length
//   timeout                           sticky watchdog flag, cleared by the next accepted pixel

module infer_ctrl
    import infer_ctrl_pkg::*;
#(
    parameter int PIX_CNT  = MNIST_PIX,
    parameter int IMG_BASE = 0,
    parameter int FADDR_W  = 15,
    parameter int TO_CYC   = 2000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic [FADDR_W-1:0] fbank_waddr,
    output logic [7:0]         fdata_w,
    output logic               fbank_wen,
    output logic               load_sel,
    output logic               core_init,
    input  logic               core_done,
    input  logic [3:0]         core_label,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [3:0]         m_label,
    output logic               len_err,
    output logic               timeout
);

    localparam int PC_W   = $clog2(PIX_CNT);
    // A disabled watchdog still needs a legal (1-bit) counter.
    localparam int WD_W   = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);
    localparam int WD_LIM = (TO_CYC == 0) ? 0 : TO_CYC - 1;

    localparam logic [PC_W-1:0]    PIX_LAST = PC_W'(PIX_CNT - 1);
    localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(WD_LIM);
    localparam logic               WD_EN    = (TO_CYC != 0);
    localparam logic [FADDR_W-1:0] BASE     = FADDR_W'(IMG_BASE);

    state_t             state_q,       state_d;
    logic [PC_W-1:0]    pix_cnt_q,     pix_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q,      wd_cnt_d;
    logic [FADDR_W-1:0] fbank_waddr_q, fbank_waddr_d;
    logic [7:0]         fdata_w_q,     fdata_w_d;
    logic               fbank_wen_q,   fbank_wen_d;
    logic               load_sel_q,    load_sel_d;
    logic               core_init_q,   core_init_d;
    logic               m_valid_q,     m_valid_d;
    logic [3:0]         m_label_q,     m_label_d;
    logic               len_err_q,     len_err_d;
    logic               timeout_q,     timeout_d;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        fbank_waddr_d = fbank_waddr_q;
        fdata_w_d     = fdata_w_q;
        fbank_wen_d   = 1'b0;
        load_sel_d    = load_sel_q;
        core_init_d   = 1'b0;
        m_valid_d     = m_valid_q;
        m_label_d     = m_label_q;
        len_err_d     = 1'b0;
        timeout_d     = timeout_q;

        unique case (state_q)
            LOAD: begin
                // s_ready is asserted throughout LOAD, so s_valid alone is a beat.
                if (s_valid) begin
                    fbank_wen_d   = 1'b1;
                    fbank_waddr_d = BASE + FADDR_W'(pix_cnt_q);
                    fdata_w_d     = s_data;
                    timeout_d     = 1'b0;
                    if (pix_cnt_q == PIX_LAST) begin
                        // A full image is always run, even if s_last was missing.
                        len_err_d = ~s_last;
                        state_d   = DRAIN;
                    end else if (s_last) begin
                        // Short image: the beat is still written, but the image
                        // is abandoned and the next pixel restarts at pixel 0.
                        len_err_d = 1'b1;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PC_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Final pixel is on the write port this cycle; release the
                // fbank mux and fire the core start together next cycle.
                load_sel_d  = 1'b0;
                core_init_d = 1'b1;
                wd_cnt_d    = '0;
                state_d     = START;
            end
            START: begin
                wd_cnt_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                // done is checked first so a done on the expiry cycle wins.
                if (core_done) begin
                    m_label_d = core_label;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
                    m_label_d = LABEL_TIMEOUT;
                    timeout_d = 1'b1;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                // m_valid is high for the whole of OUT.
                if (m_ready) begin
                    m_valid_d  = 1'b0;
                    pix_cnt_d  = '0;
                    load_sel_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            default: begin
                state_d    = LOAD;
                load_sel_d = 1'b1;
                pix_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            pix_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            fbank_waddr_q <= '0;
            fdata_w_q     <= '0;
            fbank_wen_q   <= 1'b0;
            load_sel_q    <= 1'b1;
            core_init_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            m_label_q     <= '0;
            len_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            fbank_waddr_q <= fbank_waddr_d;
            fdata_w_q     <= fdata_w_d;
            fbank_wen_q   <= fbank_wen_d;
            load_sel_q    <= load_sel_d;
            core_init_q   <= core_init_d;
            m_valid_q     <= m_valid_d;
            m_label_q     <= m_label_d;
            len_err_q     <= len_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign s_ready     = (state_q == LOAD);
    assign fbank_waddr = fbank_waddr_q;
    assign fdata_w     = fdata_w_q;
    assign fbank_wen   = fbank_wen_q;
    assign load_sel    = load_sel_q;
    assign core_init   = core_init_q;
    assign m_valid     = m_valid_q;
    assign m_label     = m_label_q;
    assign len_err     = len_err_q;
    assign timeout     = timeout_q;

    // The image must fit in the bank without the address wrapping.
    a_img_fits: assert property (@(posedge clk) disable iff (rst)
        ((PIX_CNT + IMG_BASE) <= (2 ** FADDR_W)) && (PIX_CNT >= 2));

endmodule

// File: tb/tb_infer_ctrl.sv
// Self-checking bench for infer_ctrl: table of whole-image scenarios plus reset/back-to-back sequences.
// Latency: checks exact cycle positions of the fbank write, core_init and m_valid.
// Backpressure: exercises random s_valid gaps and m_ready held low.

module tb_infer_ctrl;

    localparam int PIX = 784;
    localparam int TO  = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic [14:0] fbank_waddr;
    logic [7:0]  fdata_w;
    logic        fbank_wen;
    logic        load_sel;
    logic        core_init;
    logic        core_done = 1'b0;
    logic [3:0]  core_label = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_label;
    logic        len_err;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    bit rdy_idle = 1'b0;

    infer_ctrl #(.PIX_CNT(PIX), .IMG_BASE(0), .FADDR_W(15), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fbank_waddr(fbank_waddr), .fdata_w(fdata_w), .fbank_wen(fbank_wen),
        .load_sel(load_sel), .core_init(core_init),
        .core_done(core_done), .core_label(core_label),
        .m_valid(m_valid), .m_ready(m_ready), .m_label(m_label),
        .len_err(len_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write scoreboard: every accepted beat must appear on the fbank port
    // exactly one cycle later, at the bench's own pixel index.
    typedef struct { logic [14:0] addr; logic [7:0] dat; } wr_t;
    wr_t wq[$];
    int  pix_m = 0;

    always @(negedge clk) begin
        if (rst) begin
            wq.delete();
            pix_m = 0;
        end else begin
            if (wq.size() > 0) begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_wen", fbank_wen, 1);
                chk("wr_addr", fbank_waddr, w.addr);
                chk("wr_data", fdata_w, w.dat);
            end else if (fbank_wen) begin
                chk("wr_spurious", fbank_wen, 0);
            end
            if (s_valid && s_ready) begin
                wq.push_back('{addr: 15'(pix_m), dat: s_data});
                pix_m = (s_last || pix_m == PIX - 1) ? 0 : pix_m + 1;
            end
        end
    end

    typedef struct {
        int         nb;         // beats sent
        int         last_at;    // beat index carrying s_last, -1 for none
        bit         rnd;        // random s_valid gaps
        int         dly;        // RUN cycles before core_done, -1 = never
        logic [3:0] lbl;        // label the core model returns
        int         hold;       // cycles m_ready is held low with m_valid up
        bit         exp_short;  // image abandoned, core never started
        bit         exp_lenerr;
        logic [3:0] exp_label;
        bit         exp_to;
    } vec_t;

    vec_t vecs[7];

    // Returns #1 after the edge that accepted the final beat.
    task automatic send_image(input int nb, input int last_at, input bit rnd, input int seed);
        int i   = 0;
        int cyc = 0;
        bit acc;
        while (i < nb) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = 8'(i * 3 + seed);
            s_last  = (i == last_at);
            acc     = s_valid && s_ready;
            tick;
            if (acc) i++;
            cyc++;
            if (cyc > nb * 8 + 50) begin
                chk("send_budget", i, nb);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int seed);
        logic [3:0] held;
        send_image(v.nb, v.last_at, v.rnd, seed);
        chk("len_err", len_err, v.exp_lenerr);
        chk("beat_clears_to", timeout, 0);
        if (v.exp_short) begin
            chk("short_rdy", s_ready, 1);
            repeat (3) begin
                tick;
                chk("short_no_init", core_init, 0);
            end
            chk("short_lenerr_1cyc", len_err, 0);
            return;
        end
        // DRAIN
        chk("drain_wen", fbank_wen, 1);
        chk("drain_rdy", s_ready, 0);
        chk("drain_sel", load_sel, 1);
        chk("drain_init", core_init, 0);
        tick;
        // START
        chk("start_init", core_init, 1);
        chk("start_sel", load_sel, 0);
        chk("start_rdy", s_ready, 0);
        tick;
        // first RUN cycle
        chk("run_init_off", core_init, 0);
        chk("run_rdy", s_ready, 0);
        if (v.dly < 0) begin
            repeat (TO - 1) tick;
            chk("pre_expiry_valid", m_valid, 0);
            tick;
        end else begin
            repeat (v.dly) tick;
            chk("pre_done_valid", m_valid, 0);
            core_done  = 1'b1;
            core_label = v.lbl;
            tick;
            core_done  = 1'b0;
            core_label = '0;
        end
        chk("res_valid", m_valid, 1);
        chk("res_label", m_label, v.exp_label);
        chk("res_timeout", timeout, v.exp_to);
        chk("out_rdy", s_ready, 0);
        held = m_label;
        if (v.hold > 0) begin
            m_ready = 1'b0;
            repeat (v.hold) begin
                core_done  = 1'b1;   // must be ignored outside RUN
                core_label = 4'hA;
                tick;
                chk("hold_valid", m_valid, 1);
                chk("hold_label", m_label, v.exp_label);
            end
            core_done  = 1'b0;
            core_label = '0;
        end
        chk("hold_label_stable", m_label, held);
        m_ready = 1'b1;
        tick;
        m_ready = rdy_idle;
        chk("post_hs_valid", m_valid, 0);
        chk("post_hs_rdy", s_ready, 1);
        chk("post_hs_sel", load_sel, 1);
        chk("post_hs_to_sticky", timeout, v.exp_to);
    endtask

    initial begin
        //            nb   last rnd  dly  lbl   hold short lenerr label to
        vecs[0] = '{784, 783, 1'b0, 499, 4'h7,  0, 1'b0, 1'b0, 4'h7, 1'b0};
        vecs[1] = '{784, 783, 1'b1,  30, 4'h3, 20, 1'b0, 1'b0, 4'h3, 1'b0};
        vecs[2] = '{100,  99, 1'b0,   0, 4'h0,  0, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[3] = '{784, 783, 1'b0,  10, 4'h5,  0, 1'b0, 1'b0, 4'h5, 1'b0};
        vecs[4] = '{784,  -1, 1'b0,   5, 4'h2,  0, 1'b0, 1'b1, 4'h2, 1'b0};
        vecs[5] = '{784, 783, 1'b0,  -1, 4'h0,  3, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[6] = '{784, 783, 1'b0, 599, 4'h9,  0, 1'b0, 1'b0, 4'h9, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_load_sel", load_sel, 1);
        chk("rst_wen", fbank_wen, 0);
        chk("rst_waddr", fbank_waddr, 0);
        chk("rst_fdata", fdata_w, 0);
        chk("rst_init", core_init, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_label", m_label, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_timeout", timeout, 0);
        tick;
        tick;
        rst = 1'b0;

        // core_done while loading is ignored
        core_done  = 1'b1;
        core_label = 4'h6;
        tick;
        core_done  = 1'b0;
        core_label = '0;
        tick;
        chk("idle_done_ignored", m_valid, 0);
        chk("idle_rdy", s_ready, 1);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k * 17);

        // Reset in the middle of loading: partial image dropped, next runs clean.
        send_image(300, -1, 1'b0, 5);
        rst = 1'b1;
        #1;
        chk("mid_load_rst_wen", fbank_wen, 0);
        chk("mid_load_rst_sel", load_sel, 1);
        chk("mid_load_rst_rdy", s_ready, 1);
        tick;
        rst = 1'b0;
        run_vec(vecs[0], 99);

        // Reset while the core is running.
        send_image(784, 783, 1'b0, 7);
        repeat (20) tick;
        chk("mid_run_busy", s_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_run_rst_rdy", s_ready, 1);
        chk("mid_run_rst_sel", load_sel, 1);
        chk("mid_run_rst_init", core_init, 0);
        chk("mid_run_rst_valid", m_valid, 0);
        tick;
        rst = 1'b0;
        run_vec(vecs[3], 41);

        // Back-to-back images with m_ready tied high.
        rdy_idle = 1'b1;
        m_ready  = 1'b1;
        run_vec(vecs[3], 60);
        run_vec(vecs[4], 61);
        rdy_idle = 1'b0;
        m_ready  = 1'b0;

        tick;
        chk("wr_queue_empty", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
